// File: rtl/fpu_pkg.sv
// Shared single-precision FPU definitions: field widths, operand layout,
// classification and the unpack helpers used by the add/sub front end.
package fpu_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = 28;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int ALIGN_MAX = 28;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
    } fp32_t;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORM,
        INF,
        NAN
    } fp_class_e;

    function automatic fp_class_e fp_classify(input fp32_t x);
        fp_class_e c;
        if (x.e == EXP_MAX) begin
            c = (x.f != '0) ? NAN : INF;
        end else if (x.e == '0) begin
            c = (x.f != '0) ? DENORM : ZERO;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

    // Zero and denormals share the effective exponent 1 with no hidden bit.
    function automatic logic [EXP_W-1:0] fp_eff_exp(input fp32_t x);
        return (x.e == '0) ? 8'd1 : x.e;
    endfunction

    function automatic logic [MANT_W-1:0] fp_mant(input fp32_t x);
        return {(x.e != '0), x.f, 4'b0000};
    endfunction

endpackage

// File: rtl/sticky_rshift.sv
// 28-bit right shifter that folds every shifted-out bit into bit 0 and
// collapses to a pure sticky bit once the amount reaches the mantissa width.
module sticky_rshift
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] i_din,
    input  logic [4:0]        i_amt,
    output logic [MANT_W-1:0] o_dout
);

    logic [MANT_W-1:0] lost_mask;
    logic [MANT_W-1:0] shifted;

    generate
        for (genvar gi = 0; gi < MANT_W; gi++) begin : g_mask
            assign lost_mask[gi] = (5'(gi) < i_amt);
        end
    endgenerate

    always_comb begin
        shifted = i_din >> i_amt;
        if (i_amt >= 5'(ALIGN_MAX)) begin
            o_dout = {{(MANT_W-1){1'b0}}, |i_din};
        end else begin
            o_dout = {shifted[MANT_W-1:1], shifted[0] | (|(i_din & lost_mask))};
        end
    end

endmodule

// File: rtl/fpu_align_unpack.sv
// Add/sub operand front end: unpack, classify and order the operands in S1,
// then align the smaller mantissa in S2 behind a 2-deep valid/ready pipe.
module fpu_align_unpack
    import fpu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_a,
    input  logic [31:0]       i_b,
    input  logic              i_op_sub,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant_big,
    output logic [MANT_W-1:0] o_mant_small,
    output logic              o_sign,
    output logic              o_eff_sub,
    output logic              o_nan,
    output logic              o_inf
);

    fp32_t             fa, fb;
    fp_class_e         cls_a, cls_b;
    logic              sb_eff;
    logic [EXP_W-1:0]  ea, eb, e_diff;
    logic [MANT_W-1:0] ma, mb;
    logic              a_big;
    logic              u_sign, u_eff_sub, u_nan, u_inf;
    logic [EXP_W-1:0]  u_exp;
    logic [MANT_W-1:0] u_big, u_small;
    logic [4:0]        u_shift;

    always_comb begin
        fa        = fp32_t'(i_a);
        fb        = fp32_t'(i_b);
        cls_a     = fp_classify(fa);
        cls_b     = fp_classify(fb);
        sb_eff    = fb.s ^ i_op_sub;
        ea        = fp_eff_exp(fa);
        eb        = fp_eff_exp(fb);
        ma        = fp_mant(fa);
        mb        = fp_mant(fb);
        u_eff_sub = fa.s ^ sb_eff;
        a_big     = (ea > eb) || ((ea == eb) && (ma >= mb));
        u_exp     = a_big ? ea : eb;
        u_big     = a_big ? ma : mb;
        u_small   = a_big ? mb : ma;
        e_diff    = a_big ? (ea - eb) : (eb - ea);
        u_shift   = (e_diff >= 8'(ALIGN_MAX)) ? 5'(ALIGN_MAX) : e_diff[4:0];
        u_sign    = a_big ? fa.s : sb_eff;

        u_nan = (cls_a == NAN) || (cls_b == NAN) ||
                ((cls_a == INF) && (cls_b == INF) && u_eff_sub);
        u_inf = ((cls_a == INF) || (cls_b == INF)) && !u_nan;
        // An infinite operand dictates the sign; A wins when both are infinite.
        if (u_inf) begin
            u_sign = (cls_a == INF) ? fa.s : sb_eff;
        end
    end

    logic              s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic [MANT_W-1:0] s1_big_q, s1_big_d;
    logic [MANT_W-1:0] s1_small_q, s1_small_d;
    logic [4:0]        s1_shift_q, s1_shift_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_eff_sub_q, s1_eff_sub_d;
    logic              s1_nan_q, s1_nan_d;
    logic              s1_inf_q, s1_inf_d;

    logic              valid_q, valid_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [MANT_W-1:0] big_q, big_d;
    logic [MANT_W-1:0] small_q, small_d;
    logic              sign_q, sign_d;
    logic              eff_sub_q, eff_sub_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;

    logic              s2_advance, s1_advance, accept;
    logic [MANT_W-1:0] aligned;

    assign s2_advance = ~valid_q | i_ready;
    assign s1_advance = ~s1_valid_q | s2_advance;
    assign accept     = i_valid & s1_advance;
    assign o_ready    = s1_advance;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_exp_d     = s1_exp_q;
        s1_big_d     = s1_big_q;
        s1_small_d   = s1_small_q;
        s1_shift_d   = s1_shift_q;
        s1_sign_d    = s1_sign_q;
        s1_eff_sub_d = s1_eff_sub_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        if (s1_advance) begin
            s1_valid_d = i_valid;
        end
        if (accept) begin
            s1_exp_d     = u_exp;
            s1_big_d     = u_big;
            s1_small_d   = u_small;
            s1_shift_d   = u_shift;
            s1_sign_d    = u_sign;
            s1_eff_sub_d = u_eff_sub;
            s1_nan_d     = u_nan;
            s1_inf_d     = u_inf;
        end
    end

    sticky_rshift u_align (
        .i_din  (s1_small_q),
        .i_amt  (s1_shift_q),
        .o_dout (aligned)
    );

    always_comb begin
        valid_d   = valid_q;
        exp_d     = exp_q;
        big_d     = big_q;
        small_d   = small_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        if (s2_advance) begin
            valid_d = s1_valid_q;
        end
        // Output registers only change on a real transfer so a stalled result holds.
        if (s2_advance && s1_valid_q) begin
            exp_d     = s1_exp_q;
            big_d     = s1_big_q;
            small_d   = aligned;
            sign_d    = s1_sign_q;
            eff_sub_d = s1_eff_sub_q;
            nan_d     = s1_nan_q;
            inf_d     = s1_inf_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q   <= 1'b0;
            s1_exp_q     <= '0;
            s1_big_q     <= '0;
            s1_small_q   <= '0;
            s1_shift_q   <= '0;
            s1_sign_q    <= 1'b0;
            s1_eff_sub_q <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            valid_q      <= 1'b0;
            exp_q        <= '0;
            big_q        <= '0;
            small_q      <= '0;
            sign_q       <= 1'b0;
            eff_sub_q    <= 1'b0;
            nan_q        <= 1'b0;
            inf_q        <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_exp_q     <= s1_exp_d;
            s1_big_q     <= s1_big_d;
            s1_small_q   <= s1_small_d;
            s1_shift_q   <= s1_shift_d;
            s1_sign_q    <= s1_sign_d;
            s1_eff_sub_q <= s1_eff_sub_d;
            s1_nan_q     <= s1_nan_d;
            s1_inf_q     <= s1_inf_d;
            valid_q      <= valid_d;
            exp_q        <= exp_d;
            big_q        <= big_d;
            small_q      <= small_d;
            sign_q       <= sign_d;
            eff_sub_q    <= eff_sub_d;
            nan_q        <= nan_d;
            inf_q        <= inf_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_exp        = exp_q;
    assign o_mant_big   = big_q;
    assign o_mant_small = small_q;
    assign o_sign       = sign_q;
    assign o_eff_sub    = eff_sub_q;
    assign o_nan        = nan_q;
    assign o_inf        = inf_q;

endmodule

// File: tb/tb_fpu_align_unpack.sv
// Directed-vector bench for the add/sub operand alignment stage and its
// sticky shifter.
module tb_fpu_align_unpack;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic        i_op_sub = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_exp;
    logic [27:0] o_mant_big;
    logic [27:0] o_mant_small;
    logic        o_sign;
    logic        o_eff_sub;
    logic        o_nan;
    logic        o_inf;

    logic [27:0] sh_din = '0;
    logic [4:0]  sh_amt = '0;
    logic [27:0] sh_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_align_unpack dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_op_sub     (i_op_sub),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_exp        (o_exp),
        .o_mant_big   (o_mant_big),
        .o_mant_small (o_mant_small),
        .o_sign       (o_sign),
        .o_eff_sub    (o_eff_sub),
        .o_nan        (o_nan),
        .o_inf        (o_inf)
    );

    sticky_rshift u_sh (
        .i_din  (sh_din),
        .i_amt  (sh_amt),
        .o_dout (sh_dout)
    );

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [7:0] e_exp, input logic [27:0] e_big,
                           input logic [27:0] e_small, input logic e_sign, input logic e_eff,
                           input logic e_nan, input logic e_inf, input bit full);
        @(negedge clk);
        i_a = a; i_b = b; i_op_sub = sub; i_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, 72'(o_ready), 72'(1'b1));
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, 72'(o_valid), 72'(1'b0));
        @(negedge clk);
        chk({tag, "_vld"}, 72'(o_valid), 72'(1'b1));
        chk({tag, "_spec"}, 72'({o_nan, o_inf}), 72'({e_nan, e_inf}));
        if (!e_nan) chk({tag, "_sgn"}, 72'({o_sign, o_eff_sub}), 72'({e_sign, e_eff}));
        if (full) chk({tag, "_data"}, 72'({o_exp, o_mant_big, o_mant_small}),
                      72'({e_exp, e_big, e_small}));
        $display("vec %s a=%h b=%h sub=%0d -> exp=%h big=%h small=%h s=%0d es=%0d nan=%0d inf=%0d",
                 tag, a, b, sub, o_exp, o_mant_big, o_mant_small, o_sign, o_eff_sub, o_nan, o_inf);
    endtask

    logic [31:0] stream_b [4] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
    logic [35:0] stream_e [4] = '{{8'h7F, 28'h4000000}, {8'h7F, 28'h2000000},
                                  {8'h7F, 28'h1000000}, {8'h7F, 28'h0800000}};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] got_q[$];
        logic [35:0] held;
        int          sent;
        int          last_cyc;
        bit          seen;

        // Sticky shifter on its own.
        sh_din = 28'h0000010; sh_amt = 5'd3; #1;
        chk("sh_exact", 72'(sh_dout), 72'(28'h0000002));
        sh_din = 28'h0000014; sh_amt = 5'd3; #1;
        chk("sh_sticky", 72'(sh_dout), 72'(28'h0000003));
        sh_din = 28'h8000000; sh_amt = 5'd27; #1;
        chk("sh_d27", 72'(sh_dout), 72'(28'h0000001));
        sh_din = 28'h0000000; sh_amt = 5'd28; #1;
        chk("sh_d28_zero", 72'(sh_dout), 72'(28'h0000000));
        sh_din = 28'h0000001; sh_amt = 5'd31; #1;
        chk("sh_d31", 72'(sh_dout), 72'(28'h0000001));
        sh_din = 28'hABCDEF1; sh_amt = 5'd0; #1;
        chk("sh_d0", 72'(sh_dout), 72'(28'hABCDEF1));
        $display("sticky_rshift unit vectors done");

        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("rst_outs", 72'({o_valid, o_exp, o_mant_big, o_mant_small, o_sign, o_eff_sub, o_nan, o_inf}),
            72'(0));
        chk("rst_rdy", 72'(o_ready), 72'(1'b1));

        run_vec("add11", 32'h3F800000, 32'h3F800000, 0, 8'h7F, 28'h8000000, 28'h8000000, 0, 0, 0, 0, 1);
        run_vec("d24",   32'h3F800000, 32'h33800000, 0, 8'h7F, 28'h8000000, 28'h0000008, 0, 0, 0, 0, 1);
        run_vec("d30",   32'h3F800000, 32'h30800000, 0, 8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0, 1);
        run_vec("sub12", 32'h3F800000, 32'h40000000, 1, 8'h80, 28'h8000000, 28'h4000000, 1, 1, 0, 0, 1);
        run_vec("d26",   32'h3F800000, 32'h32800000, 0, 8'h7F, 28'h8000000, 28'h0000002, 0, 0, 0, 0, 1);
        run_vec("d27",   32'h3F800000, 32'h32000000, 0, 8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0, 1);
        run_vec("d28",   32'h3F800000, 32'h31800000, 0, 8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0, 1);
        run_vec("eqexp", 32'h3F800000, 32'h3FC00000, 1, 8'h7F, 28'hC000000, 28'h8000000, 1, 1, 0, 0, 1);
        run_vec("zero",  32'h3F800000, 32'h00000000, 0, 8'h7F, 28'h8000000, 28'h0000000, 0, 0, 0, 0, 1);
        run_vec("denrm", 32'h3F800000, 32'h00000001, 0, 8'h7F, 28'h8000000, 28'h0000001, 0, 0, 0, 0, 1);
        run_vec("tie",   32'hBF800000, 32'h3F800000, 0, 8'h7F, 28'h8000000, 28'h8000000, 1, 1, 0, 0, 1);
        run_vec("infsub", 32'h7F800000, 32'h7F800000, 1, 8'h00, 28'h0, 28'h0, 0, 1, 1, 0, 0);
        run_vec("ninf",  32'hFF800000, 32'h3F800000, 0, 8'h00, 28'h0, 28'h0, 1, 1, 0, 1, 0);
        run_vec("qnan",  32'h7FC00000, 32'h3F800000, 0, 8'h00, 28'h0, 28'h0, 0, 0, 1, 0, 0);
        run_vec("infadd", 32'h7F800000, 32'h7F800000, 0, 8'h00, 28'h0, 28'h0, 0, 0, 0, 1, 0);

        // Stream of 4 pairs with the consumer stalled for 3 cycles.
        sent = 0;
        last_cyc = -1;
        held = '0;
        for (int cyc = 0; cyc < 40 && got_q.size() < 4; cyc++) begin
            @(negedge clk);
            i_ready = (cyc >= 5);
            if (sent < 4) begin
                i_valid = 1'b1; i_a = 32'h3F800000; i_b = stream_b[sent]; i_op_sub = 1'b0;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                chk("stall_rdy", 72'(o_ready), 72'(1'b0));
                held = {o_exp, o_mant_small};
                chk("stall_head", 72'(held), 72'(stream_e[0]));
            end
            if (cyc == 3 || cyc == 4) begin
                chk("stall_hold", 72'({o_valid, o_exp, o_mant_small}), 72'({1'b1, held}));
            end
            if (i_valid && o_ready) sent++;
            if (o_valid && i_ready) begin
                got_q.push_back({o_exp, o_mant_small});
                last_cyc = cyc;
                $display("stream out #%0d cyc=%0d exp=%h small=%h", got_q.size() - 1, cyc, o_exp, o_mant_small);
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        chk("stream_cnt", 72'(got_q.size()), 72'(4));
        chk("stream_nobubble", 72'(last_cyc), 72'(8));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) chk($sformatf("stream_%0d", i), 72'(got_q[i]), 72'(stream_e[i]));
        end
        repeat (2) @(negedge clk);
        chk("stream_nodup", 72'(o_valid), 72'(1'b0));

        // Reset with two pairs in flight.
        @(negedge clk);
        i_valid = 1'b1; i_a = 32'h3F800000; i_b = 32'h3F800000; i_op_sub = 1'b0;
        @(negedge clk);
        i_b = 32'h40000000;
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b0; i_rst = 1'b1;
        #1;
        chk("rst_inflight", 72'(o_valid), 72'(1'b1));
        @(negedge clk);
        i_rst = 1'b0;
        #1;
        chk("rst_vld", 72'(o_valid), 72'(1'b0));
        chk("rst_rdy2", 72'(o_ready), 72'(1'b1));
        i_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk("rst_nostale", 72'(seen), 72'(1'b0));
        $display("reset flush done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_align_unpack.md
# fpu_align_unpack

Front-end operand stage of the floating-point add/sub datapath. Unpacks two IEEE-754 single-precision operands, classifies them, orders them by magnitude and right-aligns the smaller mantissa into the 28-bit extended format the rounding stage consumes. That format is hidden bit [27], fraction [26:4], guard [3], round [2] and sticky [1:0]. The stage is a 2-deep valid/ready pipeline that sits between the operand source and the mantissa adder.

## Interface
Parameters: none. Widths are fixed by the shared FPU package.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  operand pair presented
- o_ready  out  1  stage accepts the operand pair this cycle
- i_a  in  32  operand A, IEEE-754 single
- i_b  in  32  operand B, IEEE-754 single
- i_op_sub  in  1  1 = A − B, 0 = A + B
- o_valid  out  1  aligned result presented
- i_ready  in  1  downstream consumes the result this cycle
- o_exp  out  8  common (larger) biased exponent
- o_mant_big  out  28  larger-magnitude mantissa, unshifted
- o_mant_small  out  28  smaller-magnitude mantissa, aligned, sticky in bit 0
- o_sign  out  1  result sign before the add (sign of the big operand after B's sign is flipped for sub)
- o_eff_sub  out  1  effective subtraction
- o_nan  out  1  result is NaN
- o_inf  out  1  result is ±Inf (o_nan = 0)

## Operation
**Unpack**
- Fields: sign s, exponent e, fraction f.
- e = 0 (zero/denormal): hidden bit 0, effective exponent 1.
- Otherwise: hidden bit 1, effective exponent e.
- Mantissa m = {hidden, f, 4'b0}.
- Effective sign of B: sb' = sb ^ i_op_sub. o_eff_sub = sa ^ sb'.

**Order**
- Big operand: larger effective exponent.
- Equal exponents: larger m wins.
- Full tie: A is big.
- o_sign = sign of big. o_exp = effective exponent of big.

**Align**
- d = exp_big − exp_small (0..254).
- d ≥ 28: o_mant_small = {27'b0, |m_small}.
- Otherwise: o_mant_small = m_small >> d, and bit 0 is ORed with every bit shifted out.

**Specials** (e = 255)
- o_nan = 1 if either operand is NaN (f ≠ 0), or both are Inf with o_eff_sub = 1.
- o_inf = 1 if either operand is Inf and o_nan = 0. o_sign is then the sign of the Inf operand, or A's when both are Inf.
- Mantissas and exponent are don't-care when o_nan or o_inf is set, but must be deterministic.

## Timing
**Pipeline**
- S1 registers the unpack, compare and swap results plus d.
- S2 registers the alignment shift and the outputs.
- Latency is exactly 2 cycles from accept (i_valid & o_ready) to o_valid, when there is no backpressure.
- Throughput is 1 pair per cycle.

**Handshake**
- Each stage advances when it is empty or its successor advances.
- o_ready = ~s1_valid | s2_advance, where s2_advance = ~o_valid | i_ready.
- o_ready depends combinationally on i_ready; there is no skid buffer.
- While o_valid & ~i_ready, all outputs hold stable.
- i_a, i_b and i_op_sub are sampled only on accept.

**Reset**
- All outputs reset to 0; both stage valids reset to 0.
- Reset mid-operation discards in-flight data.
- o_valid is low the cycle after i_rst is sampled high, and no stale result appears after reset.
- o_ready is 1 while not in reset.

**Boundaries**
- A simultaneous accept and consume with both stages full keeps the pipeline full with no bubble.
- d = 27 takes the shift path; d = 28 takes the sticky-only path.

## Structure
- Shared package `fpu_pkg` holds:
  - constants EXP_W = 8, FRAC_W = 23, MANT_W = 28, EXP_MAX = 8'hFF, ALIGN_MAX = 28;
  - typedef `fp32_t` (packed s/e/f);
  - typedef `fp_class_e` {ZERO, DENORM, NORM, INF, NAN}.
- One sub-module, `sticky_rshift`: a 28-bit right shifter with a 5-bit amount, saturating at ≥ 28 and ORing shifted-out bits into bit 0. It is instantiated in S2 and unit-tested standalone.

## Test plan
- 0x3F800000 + 0x3F800000 → after 2 cycles: o_exp = 0x7F, both mantissas 0x8000000, o_eff_sub = 0, o_sign = 0.
- 0x3F800000 + 0x33800000 (d = 24) → o_mant_small = 0x0000008 (guard only); with 0x30800000 (d = 30) → o_mant_small = 0x0000001.
- 0x3F800000 − 0x40000000 → big is B: o_exp = 0x80, o_sign = 1, o_eff_sub = 1, o_mant_small = 0x4000000.
- 0x7F800000 − 0x7F800000 → o_nan = 1. 0xFF800000 + 0x3F800000 → o_inf = 1, o_nan = 0, o_sign = 1.
- Stream 4 pairs with i_ready held low for 3 cycles:
  - o_ready drops once both stages are full;
  - outputs stay stable while stalled;
  - all 4 results emerge in order, none lost or duplicated.
- Assert i_rst for 1 cycle with 2 pairs in flight → o_valid = 0 the next cycle, and no result from those pairs ever appears.
